// File: rtl/jeff_74x181_seq_pkg.sv
// Shared types and sizes for the 74x181 word sequencer: FSM encoding,
// word/nibble geometry and the nibble part-select base helper.
package jeff_74x181_seq_pkg;

  localparam int WORD_W  = 16;
  localparam int NIBBLES = 4;
  localparam int NIB_W   = WORD_W / NIBBLES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of nibble idx within a word.
  function automatic logic [3:0] nib_base(input logic [1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/jeff_74x181.sv
// Behavioural model of one 74x181 4-bit ALU slice, active-high data,
// active-low carry in/out, A=B output high when F is all ones.
module jeff_74x181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       ci_bar,
  output logic [3:0] f,
  output logic       co_bar,
  output logic       aeqb
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  // The chip's arithmetic functions are all X + Y + carry; logic mode is ~(X ^ Y).
  always_comb begin
    x      = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y      = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum    = {1'b0, x} + {1'b0, y} + {4'b0000, ~ci_bar};
    f      = m ? ~(x ^ y) : sum[3:0];
    co_bar = ~sum[4];
    aeqb   = &f;
  end

endmodule

// File: rtl/jeff_74x181_word_sequencer.sv
// Runs a 16-bit operation through one external 74x181 slice, one nibble per
// clock, rippling the slice carry through a register between nibbles.
module jeff_74x181_word_sequencer
  import jeff_74x181_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_bar,
  input  logic              start,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic [3:0]        sel,
  input  logic              mode,
  input  logic              cin,
  output logic [NIB_W-1:0]  alu_a,
  output logic [NIB_W-1:0]  alu_b,
  output logic [3:0]        alu_s,
  output logic              alu_m,
  output logic              alu_ci_bar,
  input  logic [NIB_W-1:0]  alu_f,
  input  logic              alu_co_bar,
  input  logic              alu_aeqb,
  output logic [WORD_W-1:0] result,
  output logic              cout,
  output logic              aeqb,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        idx;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] result_q;
  logic [3:0]        sel_q;
  logic              mode_q;
  logic              cin_q;
  logic              co_bar_q;
  logic              eq_q;
  logic              accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_bar) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == 2'(NIBBLES - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice drive plus status; the slice sees a fixed idle pattern outside RUN.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    alu_a      = '0;
    alu_b      = '0;
    alu_s      = 4'b0000;
    alu_m      = 1'b1;
    alu_ci_bar = 1'b1;
    if (state == RUN) begin
      alu_a      = a_q[nib_base(idx) +: NIB_W];
      alu_b      = b_q[nib_base(idx) +: NIB_W];
      alu_s      = sel_q;
      alu_m      = mode_q;
      alu_ci_bar = (idx == 2'd0) ? ~cin_q : co_bar_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      result_q <= '0;
      co_bar_q <= 1'b1;
      eq_q     <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      a_q      <= op_a;
      b_q      <= op_b;
      sel_q    <= sel;
      mode_q   <= mode;
      cin_q    <= cin;
      co_bar_q <= 1'b1;
      eq_q     <= 1'b1;
    end else if (state == RUN) begin
      result_q[nib_base(idx) +: NIB_W] <= alu_f;
      co_bar_q <= alu_co_bar;
      eq_q     <= eq_q & alu_aeqb;
      idx      <= idx + 2'd1;
    end
  end

  assign result = result_q;
  assign cout   = ~mode_q & ~co_bar_q;
  assign aeqb   = eq_q;

endmodule

// File: tb/tb_jeff_74x181_word_sequencer.sv
// Directed bench for the word sequencer wired to a 74x181 slice model;
// a monitor checks each done pulse against a queue of expected responses.
module tb_jeff_74x181_word_sequencer;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        eq;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_bar = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [3:0]  sel = '0;
  logic        mode = 1'b0;
  logic        cin = 1'b0;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  logic        alu_m, alu_ci_bar, alu_co_bar, alu_aeqb;
  logic [15:0] result;
  logic        cout, aeqb, busy, done;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  jeff_74x181_word_sequencer dut (
    .clk(clk), .rst_bar(rst_bar), .start(start), .op_a(op_a), .op_b(op_b),
    .sel(sel), .mode(mode), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_ci_bar(alu_ci_bar), .alu_f(alu_f), .alu_co_bar(alu_co_bar),
    .alu_aeqb(alu_aeqb), .result(result), .cout(cout), .aeqb(aeqb),
    .busy(busy), .done(done)
  );

  jeff_74x181 u_alu (
    .a(alu_a), .b(alu_b), .s(alu_s), .m(alu_m), .ci_bar(alu_ci_bar),
    .f(alu_f), .co_bar(alu_co_bar), .aeqb(alu_aeqb)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic chk_idle_pattern(input string tag);
    chk({tag, " alu_a"}, 32'(alu_a), 32'h0);
    chk({tag, " alu_b"}, 32'(alu_b), 32'h0);
    chk({tag, " alu_s"}, 32'(alu_s), 32'h0);
    chk({tag, " alu_m"}, 32'(alu_m), 32'h1);
    chk({tag, " alu_ci_bar"}, 32'(alu_ci_bar), 32'h1);
  endtask

  // Issue one start; returns at the negedge of the idx=0 RUN cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic m, input logic c, input logic push,
                       input logic [15:0] er, input logic eco, input logic eeq);
    exp_t e;
    @(negedge clk);
    op_a = a; op_b = b; sel = s; mode = m; cin = c; start = 1'b1;
    if (push) begin
      e.res = er; e.co = eco; e.eq = eeq; e.cyc = cyc + 5;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom_range(16'hFFFF, 0);
    op_b = $urandom_range(16'hFFFF, 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({tag, " idle timeout"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_held(input string tag, input logic [15:0] er);
    repeat (3) @(negedge clk);
    chk({tag, " held result"}, 32'(result), 32'(er));
  endtask

  // monitor: every done pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done", 32'(done), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
        chk("aeqb", 32'(aeqb), 32'(e.eq));
        chk("done latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset result", 32'(result), 32'h0);
    chk("reset cout", 32'(cout), 32'h0);
    chk("reset aeqb", 32'(aeqb), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk_idle_pattern("reset");
    rst_bar = 1'b1;

    // add: 0x1234 + 0x0FFF
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    chk("busy in run", 32'(busy), 32'h1);
    wait_idle("add");
    chk_held("add", 16'h2233);

    // carry ripple: 0xFFFF + 1, carry must reach nibbles 1..3
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk("ripple ci_bar nib0", 32'(alu_ci_bar), 32'h1);
    for (int n = 1; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("ripple ci_bar nib%0d", n), 32'(alu_ci_bar), 32'h0);
    end
    wait_idle("ripple");

    // subtract with carry-in, then equal-operand compare
    do_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b1, 16'h4FFF, 1'b1, 1'b0);
    wait_idle("sub");
    do_op(16'hABCD, 16'hABCD, 4'b0110, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    wait_idle("cmp");
    chk_held("cmp", 16'hFFFF);

    // start pulse at idx=1 must be dropped
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy start");
    repeat (8) @(negedge clk);
    chk("busy start held result", 32'(result), 32'h2233);
    chk("busy start stays idle", 32'(busy), 32'h0);

    // reset at idx=2, with start high in the reset cycle
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_bar = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    chk("midreset result", 32'(result), 32'h0);
    chk("midreset cout", 32'(cout), 32'h0);
    chk_idle_pattern("midreset");
    rst_bar = 1'b1; start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset no restart", 32'(busy), 32'h0);

    // logic mode xor
    do_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    wait_idle("logic");
    chk_held("logic", 16'h0FF0);

    repeat (4) @(negedge clk);
    chk("queue drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1);
  end

endmodule
